// File: rtl/sqrt_au_sequencer_if.sv
// sqrt_au_sequencer_if: groups the start/done request side and the shared
// abs/min/max unit (AU) side of the sqrt_au_sequencer.
//
// Handshake: the requester raises start with a/b valid. It is taken only
// while busy is low, and a and b are captured on that same clock edge. busy
// stays high until the request completes. done is a one-cycle pulse, and
// result is valid from that cycle until the next done or a reset. A start
// seen while busy is dropped and is not queued. The AU side has no
// handshake: au_out always reflects the au_a/au_b/au_sel values driven in
// the previous cycle.
interface sqrt_au_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] au_a;
   logic [WIDTH-1:0] au_b;
   logic [1:0]       au_sel;
   logic [WIDTH-1:0] au_out;
   logic [2:0]       dbg_state;

   // Environment side: square-root top level plus the AU datapath
   modport master (
      output start, a, b, au_out,
      input  busy, done, result, au_a, au_b, au_sel, dbg_state
   );

   // Sequencer side
   modport slave (
      input  start, a, b, au_out,
      output busy, done, result, au_a, au_b, au_sel, dbg_state
   );
endinterface

// File: rtl/sqrt_au_sequencer.sv
// sqrt_au_sequencer: computes sqrt(a^2+b^2) ~= max(x - x/8 + y/2, x), where
// x = max(|a|,|b|) and y = min(|a|,|b|). The absolute values, the max and
// the min are computed on a shared one-cycle-latency abs/min/max unit. The
// shift, the add/subtract and the final compare are done locally.
// Optional build macro: SQRT_AU_FORWARD_EN. It removes the WAIT state by
// forwarding au_out straight into au_b during MAX.
module sqrt_au_sequencer #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   sqrt_au_sequencer_if.slave bus
);

   // Only WIDTH=8 is supported; any other value fails elaboration
   if (WIDTH != 8) begin : g_width_check
      $error("sqrt_au_sequencer supports only WIDTH=8");
   end

   localparam logic [WIDTH-1:0] MIN_NEG       = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MIN_NEG_CLAMP = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

   localparam logic [1:0] SEL_ABS = 2'b00;
   localparam logic [1:0] SEL_MIN = 2'b10;
   localparam logic [1:0] SEL_MAX = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ABS_A = 3'd1,
      S_ABS_B = 3'd2,
      S_WAIT  = 3'd3,
      S_MAX   = 3'd4,
      S_MIN   = 3'd5,
      S_CALC  = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] ma_q, ma_d;
   logic [WIDTH-1:0] mb_q, mb_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0] au_a_c;
   logic [WIDTH-1:0] au_b_c;
   logic [1:0]       au_sel_c;
   logic [WIDTH:0]   t4;

   // Clamping -128 to -127 keeps every magnitude within the positive
   // signed range, so the AU's signed min/max compares stay correct.
   function automatic logic [WIDTH-1:0] clamp_op(input logic [WIDTH-1:0] v);
      return (v == MIN_NEG) ? MIN_NEG_CLAMP : v;
   endfunction

   // Next-state logic, AU operand/opcode decode and datapath updates
   always_comb begin
      state_d  = state_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      x_d      = x_q;
      result_d = result_q;
      au_a_c   = '0;
      au_b_c   = '0;
      au_sel_c = SEL_ABS;
      t4       = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ra_d    = clamp_op(bus.a);
               rb_d    = clamp_op(bus.b);
               state_d = S_ABS_A;
            end
         end
         S_ABS_A: begin
            au_b_c  = ra_q;
            state_d = S_ABS_B;
         end
         S_ABS_B: begin
            au_b_c  = rb_q;
            ma_d    = bus.au_out;
`ifdef SQRT_AU_FORWARD_EN
            state_d = S_MAX;
`else
            state_d = S_WAIT;
`endif
         end
`ifndef SQRT_AU_FORWARD_EN
         S_WAIT: begin
            // AU stays idle while |b| drains out of its pipeline
            mb_d    = bus.au_out;
            state_d = S_MAX;
         end
`endif
         S_MAX: begin
            au_a_c   = ma_q;
            au_sel_c = SEL_MAX;
`ifdef SQRT_AU_FORWARD_EN
            // |b| is arriving on au_out right now: bypass it and keep a copy for MIN
            au_b_c   = bus.au_out;
            mb_d     = bus.au_out;
`else
            au_b_c   = mb_q;
`endif
            state_d  = S_MIN;
         end
         S_MIN: begin
            au_a_c   = ma_q;
            au_b_c   = mb_q;
            au_sel_c = SEL_MIN;
            x_d      = bus.au_out;
            state_d  = S_CALC;
         end
         S_CALC: begin
            // au_out holds y = min(|a|,|b|) here; 9-bit sum peaks at 175
            t4 = {1'b0, x_q} - {1'b0, (x_q >> 3)} + {1'b0, (bus.au_out >> 1)};
            result_d = (t4 >= {1'b0, x_q}) ? t4[WIDTH-1:0] : x_q;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ra_q     <= '0;
         rb_q     <= '0;
         ma_q     <= '0;
         mb_q     <= '0;
         x_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         x_q      <= x_d;
         result_q <= result_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.au_a      = au_a_c;
   assign bus.au_b      = au_b_c;
   assign bus.au_sel    = au_sel_c;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sqrt_au_sequencer.sv
// tb_sqrt_au_sequencer: randomized bench for sqrt_au_sequencer with a
// behavioural AU model and a transaction-level reference model. Expected
// results are queued when a start is accepted. A negedge monitor compares
// the busy/done/au_* traffic every cycle and pops a result on each done.
module tb_sqrt_au_sequencer;
   localparam int W = 8;
`ifdef SQRT_AU_FORWARD_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 7;
`endif

   logic clk = 1'b0;
   logic rst;

   sqrt_au_sequencer_if #(.WIDTH(W)) bus ();

   sqrt_au_sequencer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- counters / scoreboard ----------------
   int n_vec  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   // Transaction-level model: cycles left in the current request (0 = idle)
   int           cnt     = 0;
   int           acc_cnt = 0;
   logic [W-1:0] pend_ca  = '0;
   logic [W-1:0] pend_cb  = '0;
   logic [W-1:0] pend_res = '0;
   logic [W-1:0] hold_res = '0;
   logic [W-1:0] e_res;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   function automatic int clamp_val(input logic [7:0] v);
      int i;
      i = int'($signed(v));
      if (i == -128) i = -127;
      return i;
   endfunction

   function automatic int iabs(input int i);
      return (i < 0) ? -i : i;
   endfunction

   function automatic logic [7:0] ref_sqrt(input logic [7:0] a, input logic [7:0] b);
      int ma, mb, x, y, t;
      ma = iabs(clamp_val(a));
      mb = iabs(clamp_val(b));
      x  = (ma > mb) ? ma : mb;
      y  = (ma > mb) ? mb : ma;
      t  = x - x / 8 + y / 2;
      return (t >= x) ? 8'(t) : 8'(x);
   endfunction

   // ---------------- AU model: one-cycle latency, no reset ----------------
   always @(posedge clk) begin
      case (bus.au_sel)
         2'b00:   bus.au_out <= 8'(iabs(int'($signed(bus.au_b))));
         2'b10:   bus.au_out <= ($signed(bus.au_a) < $signed(bus.au_b)) ? bus.au_a : bus.au_b;
         2'b11:   bus.au_out <= ($signed(bus.au_a) > $signed(bus.au_b)) ? bus.au_a : bus.au_b;
         default: bus.au_out <= 8'h00;
      endcase
   end

   // ---------------- reference model ----------------
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      = 0;
         hold_res = '0;
         exp_q.delete();
      end else if (cnt == 0) begin
         if (bus.start) begin
            pend_ca  = 8'(clamp_val(bus.a));
            pend_cb  = 8'(clamp_val(bus.b));
            pend_res = ref_sqrt(bus.a, bus.b);
            exp_q.push_back(pend_res);
            cnt      = LAT;
            acc_cnt++;
         end
      end else begin
         if (cnt == 2) hold_res = pend_res;
         cnt--;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [7:0] ea, eb;
      logic [1:0] es;
      ea = 8'h00;
      eb = 8'h00;
      es = 2'b00;
      if (cnt == LAT) begin
         eb = pend_ca;
      end else if (cnt == LAT - 1) begin
         eb = pend_cb;
      end else if (cnt == 4 || cnt == 3) begin
         ea = 8'(iabs(clamp_val(pend_ca)));
         eb = 8'(iabs(clamp_val(pend_cb)));
         es = (cnt == 4) ? 2'b11 : 2'b10;
      end
      chk("busy", 32'(bus.busy), 32'(cnt != 0));
      chk("done", 32'(bus.done), 32'(cnt == 1));
      chk("result_hold", 32'(bus.result), 32'(hold_res));
      chk("au_a", 32'(bus.au_a), 32'(ea));
      chk("au_b", 32'(bus.au_b), 32'(eb));
      chk("au_sel", 32'(bus.au_sel), 32'(es));
      if (bus.done) begin
         if (exp_q.size() == 0) begin
            fail_now("done_without_request");
         end else begin
            e_res = exp_q.pop_front();
            chk("done_result", 32'(bus.result), 32'(e_res));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (cnt != 0 && guard < 50) begin
         step();
         guard++;
      end
      if (cnt != 0) fail_now("wait_idle");
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b);
      wait_idle();
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      step();
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      int acc0;
      logic [7:0] edge_vals[6];
      edge_vals = '{8'h80, 8'h81, 8'h7f, 8'h00, 8'h01, 8'hff};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_au_sel", 32'(bus.au_sel), 32'd0);
      rst = 1'b0;
      step();

      // Directed cases
      run_op(8'd3, 8'd4);
      run_op(8'h81, 8'd127);
      run_op(8'h80, 8'd0);
      run_op(8'd0, 8'd0);
      run_op(8'd10, 8'd0);

      // Start while busy must be ignored
      run_op(8'hfa, 8'hf8);
      step();
      bus.start = 1'b1;
      bus.a     = 8'd1;
      bus.b     = 8'd1;
      step();
      bus.start = 1'b0;
      wait_idle();
      repeat (3) step();

      // Asynchronous reset while in MAX
      run_op(8'd3, 8'd4);
      guard = 0;
      while (cnt != 4 && guard < 20) begin
         step();
         guard++;
      end
      if (cnt != 4) fail_now("reach_max");
      #1;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_result", 32'(bus.result), 32'd0);
      chk("arst_au_a", 32'(bus.au_a), 32'd0);
      chk("arst_au_b", 32'(bus.au_b), 32'd0);
      chk("arst_au_sel", 32'(bus.au_sel), 32'd0);
      step();
      rst = 1'b0;
      run_op(8'hfa, 8'hf8);

      // Back-to-back with start held high
      wait_idle();
      bus.start = 1'b1;
      bus.a     = 8'd3;
      bus.b     = 8'd4;
      step();
      acc0  = acc_cnt;
      bus.a = 8'hfa;
      bus.b = 8'hf8;
      guard = 0;
      while (acc_cnt == acc0 && guard < 20) begin
         step();
         guard++;
      end
      if (acc_cnt == acc0) fail_now("back_to_back_accept");
      bus.start = 1'b0;

      // Randomized traffic with edge-value bias and start noise while busy
      for (int i = 0; i < 60; i++) begin
         logic [7:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 8'($urandom);
         run_op(ra, rb);
         for (int g = 0; g < int'($urandom_range(0, 8)); g++) begin
            if (cnt != 0 && $urandom_range(0, 2) == 0) begin
               bus.start = 1'b1;
               bus.a     = 8'($urandom);
               bus.b     = 8'($urandom);
            end
            step();
            bus.start = 1'b0;
         end
      end

      wait_idle();
      repeat (3) step();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
